// File: rtl/rb_access_controller.sv
// Sequencing FSM for the row-buffer address generator. It primes the first
// kernel rows into BRAM, streams writes and reads together, then drains reads.
//
// state  | meaning
// IDLE   | waiting for start; all strobes low
// PRIME  | writing the first KERNEL_ROWS-1 rows; no reads
// STREAM | writes and reads run concurrently, gated by occupancy
// DRAIN  | all rows written; remaining words read out
// DONE   | one-cycle done / next_image pulse
module rb_access_controller #(
    parameter int DATA_WIDTH_W = 8,
    parameter int DATA_WIDTH_R = 32,
    parameter int BRAM_DEPTH   = 16384,
    parameter int IMG_WIDTH    = 128,
    parameter int IMG_HEIGHT   = 128,
    parameter int KERNEL_ROWS  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              pix_valid,
    input  logic                              rd_ready,
    output logic                              en_e,
    output logic                              en_w,
    output logic                              en_r,
    output logic                              next_image,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   rows_written
);

    localparam int RATIO       = DATA_WIDTH_R / DATA_WIDTH_W;
    localparam int WPR         = IMG_WIDTH / RATIO;
    localparam int CAP         = BRAM_DEPTH / DATA_WIDTH_W;
    localparam int WORDS       = CAP / RATIO;
    localparam int READS_TOTAL = IMG_HEIGHT * WPR;
    localparam int SUB_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int CRD_W       = $clog2(WORDS + 1);
    localparam int ROW_W       = $clog2(IMG_HEIGHT + 1);
    localparam int RD_W        = $clog2(READS_TOTAL + 1);
    localparam int OCC_W       = $clog2(CAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [SUB_W-1:0]   r_sub_cnt;
    logic [CRD_W-1:0]   r_credit;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_rows;
    logic [RD_W-1:0]    r_reads;

    logic [OCC_W-1:0]   w_occupancy;
    logic               w_en_w;
    logic               w_en_r;
    logic               w_word_done;
    logic               w_row_done;

    // Occupancy comes from registered values only, so a freeing read
    // re-enables writes one cycle later.
    always_comb begin
        w_occupancy = OCC_W'(r_credit) * OCC_W'(RATIO) + OCC_W'(r_sub_cnt);
        w_en_w      = pix_valid && ((r_state == S_PRIME) || (r_state == S_STREAM))
                      && (w_occupancy < OCC_W'(CAP));
        w_en_r      = rd_ready && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                      && (r_credit != '0);
        w_word_done = w_en_w && (r_sub_cnt == SUB_W'(RATIO - 1));
        w_row_done  = w_en_w && (r_col == COL_W'(IMG_WIDTH - 1));
    end

    assign en_w         = w_en_w;
    assign en_e         = w_en_w;
    assign en_r         = w_en_r;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign next_image   = (r_state == S_DONE);
    assign rows_written = r_rows;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sub_cnt <= '0;
            r_credit  <= '0;
            r_col     <= '0;
            r_rows    <= '0;
            r_reads   <= '0;
        end else begin
            if (w_en_w) begin
                r_sub_cnt <= w_word_done ? '0 : r_sub_cnt + 1'b1;
                if (w_row_done) begin
                    r_col  <= '0;
                    r_rows <= r_rows + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_word_done && !w_en_r) begin
                r_credit <= r_credit + 1'b1;
            end else if (!w_word_done && w_en_r) begin
                r_credit <= r_credit - 1'b1;
            end

            if (w_en_r) begin
                r_reads <= r_reads + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_PRIME;
                        r_sub_cnt <= '0;
                        r_credit  <= '0;
                        r_col     <= '0;
                        r_rows    <= '0;
                        r_reads   <= '0;
                    end
                end
                S_PRIME: begin
                    if (w_row_done && (r_rows == ROW_W'(KERNEL_ROWS - 2))) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_row_done && (r_rows == ROW_W'(IMG_HEIGHT - 1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_en_r && (r_reads == RD_W'(READS_TOTAL - 1))) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb_access_controller.sv
// Self-checking bench for rb_access_controller; a pixel/word count model
// predicts every strobe and status output cycle by cycle.
module tb_rb_access_controller;

    localparam int IMG_WIDTH   = 8;
    localparam int IMG_HEIGHT  = 6;
    localparam int KERNEL_ROWS = 3;
    localparam int DW_W        = 8;
    localparam int DW_R        = 32;
    localparam int BRAM        = 256;
    localparam int RATIO       = DW_R / DW_W;
    localparam int CAP         = BRAM / DW_W;
    localparam int TOT_PIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam int PRIME_PIX   = (KERNEL_ROWS - 1) * IMG_WIDTH;
    localparam int TOT_RD      = TOT_PIX / RATIO;

    logic       clk = 1'b0;
    logic       reset, start, pix_valid, rd_ready;
    logic       en_e, en_w, en_r, next_image, busy, done;
    logic [2:0] rows_written;

    rb_access_controller #(
        .DATA_WIDTH_W(DW_W), .DATA_WIDTH_R(DW_R), .BRAM_DEPTH(BRAM),
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .KERNEL_ROWS(KERNEL_ROWS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .rd_ready(rd_ready), .en_e(en_e), .en_w(en_w), .en_r(en_r),
        .next_image(next_image), .busy(busy), .done(done),
        .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: pixels written and words read in the current image.
    int m_w, m_r;
    bit m_active, m_done_cyc;
    logic exp_w, exp_r, exp_done, exp_busy;
    logic [2:0] exp_rows;
    logic [8:0] act_v, exp_v;
    int cw, cr;

    task automatic apply(input logic rs, input logic st, input logic pv, input logic rr);
        reset = rs; start = st; pix_valid = pv; rd_ready = rr;
        exp_w    = m_active && pv && (m_w < TOT_PIX) && ((m_w - m_r * RATIO) < CAP);
        exp_r    = m_active && rr && (m_w >= PRIME_PIX) && ((m_w / RATIO) > m_r);
        exp_done = m_done_cyc;
        exp_busy = m_active || m_done_cyc;
        exp_rows = 3'(m_w / IMG_WIDTH);
        @(negedge clk);
        act_v = {en_e, en_w, en_r, done, next_image, busy, rows_written};
        exp_v = {exp_w, exp_w, exp_r, exp_done, exp_done, exp_busy, exp_rows};
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_w = 0; m_r = 0; m_active = 0; m_done_cyc = 0;
        end else if (m_done_cyc) begin
            m_done_cyc = 0;
        end else if (!m_active) begin
            if (start) begin m_active = 1; m_w = 0; m_r = 0; end
        end else begin
            if (exp_w) m_w++;
            if (exp_r) m_r++;
            if (m_r == TOT_RD) begin m_active = 0; m_done_cyc = 1; end
        end
        #1;
    endtask

    task automatic test_reset();
        m_w = 0; m_r = 0; m_active = 0; m_done_cyc = 0;
        reset = 1'b1; start = 1'b1; pix_valid = 1'b1; rd_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_hold c%0d: got %b want %b", c, act_v, exp_v); end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1);
            n_cmp++; if (act_v !== 9'd0) begin n_fail++; $display("FAIL reset_idle c%0d: got %b want %b", c, act_v, 9'd0); end
            tick();
        end
    endtask

    task automatic test_prime();
        int first_r = -1;
        int nw = 0;
        cw = 0; cr = 0;
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL prime_start: got %b want %b", act_v, exp_v); end
        tick();
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL prime c%0d: got %b want %b", c, act_v, exp_v); end
            if (en_r && first_r < 0) first_r = c;
            if (en_w && first_r < 0) nw++;
            if (c == 16) begin
                n_cmp++; if (rows_written !== 3'd2) begin n_fail++; $display("FAIL prime_rows: got %0d want 2", rows_written); end
            end
            cw += int'(en_w); cr += int'(en_r);
            tick();
        end
        n_cmp++; if (nw !== 16) begin n_fail++; $display("FAIL prime_writes: got %0d want 16", nw); end
        n_cmp++; if (first_r !== 16) begin n_fail++; $display("FAIL prime_first_read: got cycle %0d want 16", first_r); end
    endtask

    task automatic test_completion();
        bit seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL complete c%0d: got %b want %b", c, act_v, exp_v); end
            cw += int'(en_w); cr += int'(en_r);
            if (done) seen = 1;
            tick();
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL complete_timeout: got no done want done"); end
        n_cmp++; if (cw !== TOT_PIX) begin n_fail++; $display("FAIL complete_writes: got %0d want %0d", cw, TOT_PIX); end
        n_cmp++; if (cr !== TOT_RD) begin n_fail++; $display("FAIL complete_reads: got %0d want %0d", cr, TOT_RD); end
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (act_v !== {6'b0, 3'd6}) begin n_fail++; $display("FAIL complete_after: got %b want %b", act_v, {6'b0, 3'd6}); end
        tick();
    endtask

    task automatic test_full_stall();
        int nw = 0;
        int n4 = 0;
        bit seen = 0;
        apply(1'b0, 1'b1, 1'b1, 1'b0); tick();
        for (int c = 0; c < 36; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall c%0d: got %b want %b", c, act_v, exp_v); end
            nw += int'(en_w);
            tick();
        end
        n_cmp++; if (nw !== CAP) begin n_fail++; $display("FAIL stall_writes: got %0d want %0d", nw, CAP); end
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if ({en_r, en_w} !== 2'b10) begin n_fail++; $display("FAIL stall_pulse: got en_r,en_w=%b want 10", {en_r, en_w}); end
        tick();
        for (int c = 0; c < 8; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall_refill c%0d: got %b want %b", c, act_v, exp_v); end
            if (c == 0) begin
                n_cmp++; if (en_w !== 1'b1) begin n_fail++; $display("FAIL stall_reenable: got %b want 1", en_w); end
            end
            n4 += int'(en_w);
            tick();
        end
        n_cmp++; if (n4 !== RATIO) begin n_fail++; $display("FAIL stall_refill_count: got %0d want %0d", n4, RATIO); end
        for (int c = 0; c < 2000 && !seen; c++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL stall_finish c%0d: got %b want %b", c, act_v, exp_v); end
            if (done) seen = 1;
            tick();
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
    endtask

    task automatic test_gapped();
        bit seen = 0;
        apply(1'b0, 1'b1, 1'b0, 1'b0); tick();
        for (int c = 0; c < 2000 && !seen; c++) begin
            apply(1'b0, 1'b0, (c % 2) == 0, 1'($urandom_range(0, 1)));
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL gapped c%0d: got %b want %b", c, act_v, exp_v); end
            n_cmp++; if (en_w && !pix_valid) begin n_fail++; $display("FAIL gapped_wr c%0d: got en_w=1 want 0 with pix_valid=0", c); end
            if (done) seen = 1;
            tick();
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL gapped_timeout: got no done want done"); end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        int first_r = -1;
        bit seen = 0;
        apply(1'b0, 1'b1, 1'b1, 1'b1); tick();
        for (int c = 0; c < 200 && nw < 20; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL midrst_run c%0d: got %b want %b", c, act_v, exp_v); end
            nw += int'(en_w);
            tick();
        end
        apply(1'b1, 1'b0, 1'b1, 1'b1); tick();
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (act_v !== 9'd0) begin n_fail++; $display("FAIL midrst_clear: got %b want %b", act_v, 9'd0); end
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b1); tick();
        nw = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1);
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL midrst_reprime c%0d: got %b want %b", c, act_v, exp_v); end
            if (en_r && first_r < 0) first_r = c;
            if (en_w && first_r < 0) nw++;
            if (done) seen = 1;
            tick();
        end
        n_cmp++; if (nw !== PRIME_PIX) begin n_fail++; $display("FAIL midrst_prime_writes: got %0d want %0d", nw, PRIME_PIX); end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL midrst_timeout: got no done want done"); end
    endtask

    task automatic test_random_images();
        logic st;
        for (int c = 0; c < 1500; c++) begin
            st = m_done_cyc ? 1'b1 : 1'($urandom_range(0, 19) == 0);
            apply(1'b0, st, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            n_cmp++; if (act_v !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %b want %b", c, act_v, exp_v); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_completion();
        test_full_stall();
        test_gapped();
        test_reset_mid();
        test_random_images();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rb_access_controller.md
Name: rb_access_controller

Overview:
- Sequencing FSM for the row-buffer address generator: drives en_e, en_w, en_r and next_image for one image at a time.
- Primes KERNEL_ROWS-1 rows into the BRAM, then streams writes and reads concurrently, then drains the remaining reads.
- Tracks buffer occupancy so reads never overtake writes and writes never overrun BRAM capacity.
- Sits between the external pixel source and the downstream kernel datapath, alongside address_generator_module.

Parameters:
- DATA_WIDTH_W, 8, write (pixel) width in bits.
- DATA_WIDTH_R, 32, read word width in bits; must be a multiple of DATA_WIDTH_W.
- BRAM_DEPTH, 16384, BRAM size in bits.
- IMG_WIDTH, 128, pixels per row; must be a multiple of RATIO.
- IMG_HEIGHT, 128, rows per image; must be >= KERNEL_ROWS.
- KERNEL_ROWS, 3, kernel height; requires KERNEL_ROWS*IMG_WIDTH <= CAP.
- Derived values:
  - RATIO = DATA_WIDTH_R/DATA_WIDTH_W
  - WPR = IMG_WIDTH/RATIO
  - CAP = BRAM_DEPTH/DATA_WIDTH_W (pixels)

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an image when in IDLE, ignored otherwise.
- pix_valid  in  1  external memory presents a pixel this cycle.
- rd_ready  in  1  downstream accepts a read word this cycle.
- en_e  out  1  advance the external memory address.
- en_w  out  1  BRAM write strobe / advance the write address.
- en_r  out  1  BRAM read strobe / advance the read address.
- next_image  out  1  one-cycle pulse that resets the address generator.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at image completion.
- rows_written  out  clog2(IMG_HEIGHT+1)  count of complete rows written.

Behaviour:
- Reset:
  - One clock edge with reset=1 forces state IDLE.
  - All counters clear.
  - All outputs go to 0.
  - This applies from any state, including mid-image; no next_image pulse is issued on reset.
- States and transitions:
  - IDLE -> PRIME on start.
  - PRIME -> STREAM on the write that completes row KERNEL_ROWS-1.
  - STREAM -> DRAIN on the write that completes row IMG_HEIGHT.
  - DRAIN -> DONE on the read that makes reads_total == IMG_HEIGHT*WPR.
  - DONE -> IDLE unconditionally after one cycle.
- Strobe timing:
  - Strobes are combinational from registered state/counters plus the handshake inputs.
  - Each strobe takes effect on the same rising edge at which it is high.
- Write strobe:
  - en_w = pix_valid & (state in PRIME or STREAM) & (occupancy < CAP).
  - en_e == en_w on every cycle.
- Read strobe:
  - en_r = rd_ready & (state in STREAM or DRAIN) & (credit > 0).
  - Reads never occur in PRIME.
- Occupancy accounting:
  - sub_cnt (0..RATIO-1) increments on each write.
  - On the write that wraps sub_cnt from RATIO-1 to 0, credit increments by 1.
  - credit decrements by 1 on each read.
  - If a word-completing write and a read occur in the same cycle, credit is unchanged.
  - occupancy = credit*RATIO + sub_cnt, in pixels.
  - Full (occupancy == CAP): en_w is held 0 until a read frees space. Occupancy is evaluated from registered values, so a write is re-enabled the cycle after the freeing read.
- Column/row counters:
  - Column counter wraps at IMG_WIDTH-1; rows_written increments on that wrap.
  - rows_written holds its final value through DRAIN and DONE.
  - It clears on the next start.
- DONE cycle:
  - done=1 and next_image=1 for exactly one cycle.
  - en_e, en_w and en_r are 0.
- Edge cases:
  - start while busy: ignored.
  - start in the same cycle as DONE: ignored; a new start must arrive in IDLE.
- Widths: all counters are sized by clog2 of their maximum value + 1; no counter overflow is legal under the parameter constraints above.

Test Plan:
Bench configuration: IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_ROWS=3, DATA_WIDTH_W=8, DATA_WIDTH_R=32, BRAM_DEPTH=256 (CAP=32, RATIO=4, WPR=2).
- Reset / idle:
  - Stimulus: hold reset 2 cycles, pulse start during reset, pix_valid=1.
  - Required: all outputs stay 0 and state stays IDLE after reset falls.
- Prime:
  - Stimulus: start, then pix_valid=1 and rd_ready=1 continuously.
  - Required: exactly 16 consecutive en_w/en_e cycles with en_r=0; rows_written=2 after the 16th write; en_r first high on the next cycle.
- Full stall:
  - Stimulus: rd_ready=0 after start, pix_valid=1.
  - Required: en_w drops after the 32nd write (occupancy 32).
  - Then pulse rd_ready for 1 cycle: one en_r; en_w re-asserts the next cycle for exactly 4 writes, then stalls again.
- Completion:
  - Stimulus: stream the full image with rd_ready=1.
  - Required: 48 writes and 12 reads in total; DRAIN is entered after write 48.
  - After read 12: done and next_image each high for exactly 1 cycle, then busy=0 and rows_written=6.
- Gapped input:
  - Stimulus: pix_valid toggling every cycle.
  - Required: en_w high only on pix_valid cycles; en_e==en_w on every cycle; no reads while credit==0.
- Reset mid-STREAM:
  - Stimulus: assert reset 1 cycle after 20 writes.
  - Required: the next cycle shows all outputs 0, rows_written=0 and no next_image pulse.
  - A new start then re-primes from zero (16 writes before the first en_r).
